// File: rtl/lines_matrix_scanner_pkg.sv
// Shared constants and types for the water-level LED matrix scanner.
package lines_matrix_scanner_pkg;

  localparam int NUM_ROWS    = 7;
  localparam int NUM_COLS    = 5;
  localparam int LEVEL_WIDTH = 2;

  // Column patterns: level shown as a bar that grows out from the centre LED.
  localparam logic [NUM_COLS-1:0] COL_EMPTY = 5'b00000;
  localparam logic [NUM_COLS-1:0] COL_LOW   = 5'b00100;
  localparam logic [NUM_COLS-1:0] COL_MID   = 5'b01110;
  localparam logic [NUM_COLS-1:0] COL_FULL  = 5'b11111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/lines_matrix_scanner_decoder.sv
// Combinational translation of a 2-bit level code into a column pattern.
module level_col_decoder
  import lines_matrix_scanner_pkg::*;
(
  input  logic [LEVEL_WIDTH-1:0] level_i,
  output logic [NUM_COLS-1:0]    col_o
);

  // One pattern per level code.
  always_comb begin
    col_o = COL_EMPTY;
    case (level_i)
      2'b00:   col_o = COL_EMPTY;
      2'b01:   col_o = COL_LOW;
      2'b10:   col_o = COL_MID;
      2'b11:   col_o = COL_FULL;
      default: col_o = COL_EMPTY;
    endcase
  end

endmodule

// File: rtl/lines_matrix_scanner.sv
// Row-multiplexed LED matrix scanner with per-frame input snapshot.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | all rows and columns off, guard gap before row row_q lights
// ST_SHOW  | row row_q driven low, columns show its snapshotted level
module lines_matrix_scanner
  import lines_matrix_scanner_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            init,
  input  logic [NUM_ROWS*LEVEL_WIDTH-1:0] lines,
  input  logic                            freeze,
  output logic [NUM_ROWS-1:0]             row_n,
  output logic [NUM_COLS-1:0]             col,
  output logic [2:0]                      row_idx,
  output logic                            frame_start
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(NUM_ROWS - 1);

  scan_state_e                     state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [2:0]                      row_q, row_d;
  logic [NUM_ROWS*LEVEL_WIDTH-1:0] snap_q, snap_d;

  logic [LEVEL_WIDTH-1:0] level_w;
  logic [NUM_COLS-1:0]    dec_col_w;

  // A frame begins on the first blank cycle of row 0; init masks the pulse
  // because the reset state itself looks like a frame start.
  assign frame_start = (state_q == ST_BLANK) && (row_q == 3'd0) &&
                       (cnt_q == '0) && !init;
  assign row_idx = row_q;

  // State, counter, row pointer and snapshot registers.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= 3'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
    end
  end

  // Next-state: blank gap, then dwell, then advance to the next row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    snap_d  = snap_q;

    if (frame_start && !freeze) begin
      snap_d = lines;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Pick the snapshotted level code of the row being scanned.
  always_comb begin
    level_w = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_q == 3'(r)) begin
        level_w = snap_q[r*LEVEL_WIDTH +: LEVEL_WIDTH];
      end
    end
  end

  level_col_decoder u_dec (
    .level_i (level_w),
    .col_o   (dec_col_w)
  );

  // Drive the matrix only while showing; everything is off during blanking.
  always_comb begin
    row_n = '1;
    col   = COL_EMPTY;
    if (state_q == ST_SHOW) begin
      row_n = ~(7'(1) << row_q);
      col   = dec_col_w;
    end
  end

endmodule

// File: tb/tb_lines_matrix_scanner.sv
module tb_lines_matrix_scanner;

  logic        clk = 1'b0;
  logic [2:0]  init_v = 3'b111;
  logic [13:0] lines = 14'h0;
  logic        freeze = 1'b0;

  logic [6:0] rn_a, rn_b, rn_c;
  logic [4:0] col_a, col_b, col_c;
  logic [2:0] ri_a, ri_b, ri_c;
  logic       fs_a, fs_b, fs_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lines_matrix_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .init(init_v[0]), .lines(lines), .freeze(freeze),
    .row_n(rn_a), .col(col_a), .row_idx(ri_a), .frame_start(fs_a));

  lines_matrix_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .init(init_v[1]), .lines(lines), .freeze(freeze),
    .row_n(rn_b), .col(col_b), .row_idx(ri_b), .frame_start(fs_b));

  lines_matrix_scanner dut_c (
    .clk(clk), .init(init_v[2]), .lines(lines), .freeze(freeze),
    .row_n(rn_c), .col(col_c), .row_idx(ri_c), .frame_start(fs_c));

  // ---------------- reference model ----------------
  // Each instance is described only by the number of cycles since reset
  // release and the snapshot taken at the most recent frame boundary.
  int          t_m    [3];
  logic [13:0] snap_m [3];

  function automatic int bl(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 8;
  endfunction

  function automatic int dw(int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 1000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (init_v[i]) begin
        t_m[i]    <= 0;
        snap_m[i] <= 14'h0;
      end else begin
        if ((t_m[i] % (7 * (bl(i) + dw(i)))) == 0 && !freeze) snap_m[i] <= lines;
        t_m[i] <= t_m[i] + 1;
      end
    end
  end

  // Expected {row_n, col, row_idx, frame_start}.
  function automatic logic [15:0] model_out(int i);
    int per, p, r, w, n;
    logic [1:0]  code;
    logic [6:0]  rn;
    logic [4:0]  c;
    logic [13:0] s;
    if (init_v[i]) return {7'h7F, 5'h00, 3'd0, 1'b0};
    per = bl(i) + dw(i);
    p   = t_m[i] % (7 * per);
    r   = p / per;
    w   = p % per;
    rn  = 7'h7F;
    c   = 5'h00;
    if (w >= bl(i)) begin
      s    = snap_m[i];
      code = s[2*r +: 2];
      // number of lit LEDs, centred in the 5-wide row
      n  = (code == 2'd0) ? 0 : (code == 2'd1) ? 1 : (code == 2'd2) ? 3 : 5;
      c  = 5'(((1 << n) - 1) << ((5 - n) / 2));
      rn = 7'h7F ^ 7'(1 << r);
    end
    return {rn, c, 3'(r), (p == 0)};
  endfunction

  function automatic logic [15:0] obs(int i);
    case (i)
      0:       return {rn_a, col_a, ri_a, fs_a};
      1:       return {rn_b, col_b, ri_b, fs_b};
      default: return {rn_c, col_c, ri_c, fs_c};
    endcase
  endfunction

  logic [4:0] exp_cols [7] = '{5'b00100, 5'b01110, 5'b11111, 5'b00000,
                               5'b00100, 5'b01110, 5'b11111};
  localparam logic [13:0] PATTERN = 14'b11_10_01_00_11_10_01;

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] e;
    init_v = 3'b111;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = model_out(i);
      n_tests++;
      if (obs(i) !== e) begin
        n_fail++;
        $display("FAIL reset_idle inst=%0d got=%h exp=%h", i, obs(i), e);
      end
    end
    init_v[0] = 1'b0;
    #1;
    n_tests++;
    if (fs_a !== 1'b1 || ri_a !== 3'd0 || rn_a !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_release fs=%b ri=%0d rn=%h exp fs=1 ri=0 rn=7f", fs_a, ri_a, rn_a);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (rn_a !== 7'h7E) begin
      n_fail++;
      $display("FAIL reset_pre_show rn=%h exp=7e", rn_a);
    end
    init_v[0] = 1'b1;
    #1;
    n_tests++;
    if (rn_a !== 7'h7F || col_a !== 5'h00 || fs_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async rn=%h col=%b fs=%b exp rn=7f col=00000 fs=0", rn_a, col_a, fs_a);
    end
    @(negedge clk);
    init_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (fs_a !== (k == 0) || ri_a !== 3'd0 || rn_a !== ((k < 2) ? 7'h7F : 7'h7E)) begin
        n_fail++;
        $display("FAIL reset_restart k=%0d fs=%b ri=%0d rn=%h", k, fs_a, ri_a, rn_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_scan();
    int last_fs, nfs;
    logic [15:0] e;
    lines = PATTERN;
    freeze = 1'b0;
    init_v[0] = 1'b1;
    @(negedge clk);
    init_v[0] = 1'b0;
    last_fs = -1;
    nfs = 0;
    for (int k = 0; k < 84; k++) begin
      #1;
      e = model_out(0);
      n_tests++;
      if (obs(0) !== e) begin
        n_fail++;
        $display("FAIL full_scan t=%0d got=%h exp=%h", k, obs(0), e);
      end
      if (rn_a !== 7'h7F) begin
        n_tests++;
        if (col_a !== exp_cols[ri_a] || rn_a !== (7'h7F ^ (7'h01 << ri_a))) begin
          n_fail++;
          $display("FAIL full_scan_row row=%0d col=%b exp=%b rn=%h", ri_a, col_a, exp_cols[ri_a], rn_a);
        end
      end
      if (fs_a) begin
        n_tests++;
        if (k % 42 != 0 || (last_fs >= 0 && k - last_fs != 42)) begin
          n_fail++;
          $display("FAIL full_scan_fs t=%0d prev=%0d exp interval 42", k, last_fs);
        end
        last_fs = k;
        nfs++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (nfs != 2) begin
      n_fail++;
      $display("FAIL full_scan_fs_count got=%0d exp=2", nfs);
    end
  endtask

  task automatic test_tear_free();
    int frames;
    bit changed;
    logic [15:0] e;
    frames = 0;
    changed = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (fs_a) frames++;
      if (frames >= 3) break;
      e = model_out(0);
      n_tests++;
      if (obs(0) !== e) begin
        n_fail++;
        $display("FAIL tear_model k=%0d got=%h exp=%h", k, obs(0), e);
      end
      if (rn_a !== 7'h7F) begin
        n_tests++;
        if (col_a !== ((frames == 1) ? exp_cols[ri_a] : 5'h1F)) begin
          n_fail++;
          $display("FAIL tear_row frame=%0d row=%0d col=%b", frames, ri_a, col_a);
        end
        if (frames == 1 && ri_a == 3'd3 && !changed) begin
          lines = 14'h3FFF;
          changed = 1;
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (frames != 3 || !changed) begin
      n_fail++;
      $display("FAIL tear_progress frames=%0d changed=%0d exp 3/1", frames, changed);
    end
  endtask

  task automatic test_freeze();
    int frames;
    logic [15:0] e;
    frames = 0;
    lines = 14'h0000;
    freeze = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (fs_a) begin
        frames++;
        if (frames == 2) freeze = 1'b0;
      end
      if (frames >= 3) break;
      if (frames == 1 && k == 20) freeze = 1'b0;
      if (frames == 1 && k == 22) freeze = 1'b1;
      e = model_out(0);
      n_tests++;
      if (obs(0) !== e) begin
        n_fail++;
        $display("FAIL freeze_model k=%0d got=%h exp=%h", k, obs(0), e);
      end
      if (rn_a !== 7'h7F) begin
        n_tests++;
        if (col_a !== ((frames == 1) ? 5'h1F : 5'h00)) begin
          n_fail++;
          $display("FAIL freeze_row frame=%0d row=%0d col=%b", frames, ri_a, col_a);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (frames != 3) begin
      n_fail++;
      $display("FAIL freeze_progress frames=%0d exp=3", frames);
    end
  endtask

  task automatic test_min_timing();
    logic [15:0] e;
    lines = 14'($urandom);
    freeze = 1'b0;
    init_v[1] = 1'b1;
    @(negedge clk);
    init_v[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      e = model_out(1);
      n_tests++;
      if (obs(1) !== e) begin
        n_fail++;
        $display("FAIL min_model t=%0d got=%h exp=%h", k, obs(1), e);
      end
      n_tests++;
      if ((rn_b === 7'h7F) !== (k % 2 == 0) || fs_b !== (k % 14 == 0) || ri_b !== 3'((k % 14) / 2)) begin
        n_fail++;
        $display("FAIL min_timing t=%0d rn=%h fs=%b ri=%0d", k, rn_b, fs_b, ri_b);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_default_timing();
    int last_fs, nfs, first_show;
    logic [15:0] e;
    lines = 14'($urandom);
    init_v[2] = 1'b1;
    @(negedge clk);
    init_v[2] = 1'b0;
    last_fs = -1;
    nfs = 0;
    first_show = -1;
    for (int k = 0; k <= 2 * 7056; k++) begin
      #1;
      e = model_out(2);
      n_tests++;
      if (obs(2) !== e) begin
        n_fail++;
        $display("FAIL default_model t=%0d got=%h exp=%h", k, obs(2), e);
      end
      if (first_show < 0 && rn_c !== 7'h7F) first_show = k;
      if (fs_c) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (k - last_fs != 7056) begin
            n_fail++;
            $display("FAIL default_interval got=%0d exp=7056", k - last_fs);
          end
        end
        last_fs = k;
        nfs++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (first_show != 8 || nfs != 3) begin
      n_fail++;
      $display("FAIL default_first_show got=%0d nfs=%0d exp 8/3", first_show, nfs);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    init_v[1:0] = 2'b11;
    @(negedge clk);
    init_v[1:0] = 2'b00;
    for (int k = 0; k < 600; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        e = model_out(i);
        n_tests++;
        if (obs(i) !== e) begin
          n_fail++;
          $display("FAIL random inst=%0d k=%0d got=%h exp=%h", i, k, obs(i), e);
        end
      end
      if ($urandom_range(7) == 0) lines = 14'($urandom);
      if ($urandom_range(15) == 0) freeze = ~freeze;
      if (init_v[0]) init_v[0] = 1'b0;
      else if ($urandom_range(149) == 0) init_v[0] = 1'b1;
      @(negedge clk);
    end
    init_v[0] = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_tear_free();
    test_freeze();
    test_min_timing();
    test_default_timing();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lines_matrix_scanner.md
Name: lines_matrix_scanner

Overview:
Display stage directly downstream of the 7-row water-level FSM chain. Consumes its 14-bit `lines` bus (seven 2-bit level codes, row 0 = `lines[1:0]` at the bottom, row 6 = `lines[13:12]` at the top). Time-multiplexes those codes onto a 7x5 LED matrix: one row is driven at a time, with a blanking gap between rows to suppress ghosting. Input is snapshotted once per frame, so a level change never tears mid-frame.

Parameters:
DWELL_CYCLES, 1000, clock cycles a row is lit (≥1)
BLANK_CYCLES, 8, clock cycles all rows/columns are off before each row is lit (≥1)

Ports:
clk  input  1  system clock
init  input  1  asynchronous active-high reset
lines  input  14  level codes from the row FSM chain, row r = lines[2r+1:2r]
freeze  input  1  when high, the per-frame snapshot is not refreshed (display held)
row_n  output  7  active-low one-hot row drive, bit r = physical row r
col  output  5  active-high column drive for the currently lit row
row_idx  output  3  index of the row currently being scanned, 0..6
frame_start  output  1  one-cycle pulse marking the first cycle of each frame

Behaviour:
- Reset (`init` high, asynchronous): state=BLANK, row_idx=0, cnt=0, snapshot=14'b0.
  - Outputs during reset: row_n=7'h7F, col=5'b0, frame_start=0.
  - Outputs go off immediately on `init` assertion, without waiting for a clock edge.
- FSM states:
  - BLANK: row_n=7'h7F, col=0. cnt counts 0..BLANK_CYCLES-1; at cnt=BLANK_CYCLES-1 go to SHOW, cnt←0.
  - SHOW: row_n has bit row_idx low, all other bits high; col=decode(snapshot[2*row_idx+1:2*row_idx]). cnt counts 0..DWELL_CYCLES-1; at cnt=DWELL_CYCLES-1 go to BLANK, cnt←0, row_idx←row_idx+1.
  - Row wrap: 6→0.
- Level decode (col[4:0]): 00→00000, 01→00100, 10→01110, 11→11111.
- Snapshot:
  - frame_start=1 exactly when state=BLANK, row_idx=0, cnt=0 (and init low).
  - On that clock edge, snapshot←lines if freeze=0; snapshot holds if freeze=1.
  - The first cycle after reset release is a frame start.
- Timing:
  - Row period = BLANK_CYCLES+DWELL_CYCLES.
  - Frame period = 7*(BLANK_CYCLES+DWELL_CYCLES); 7056 cycles with defaults.
- Changes on `lines` between frame starts have no visible effect until the next frame start.
- freeze toggling mid-frame has no effect until the next frame start.
- BLANK_CYCLES=1 or DWELL_CYCLES=1: the state lasts exactly one cycle; no off-by-one.
- Counter width: $clog2(max(BLANK_CYCLES,DWELL_CYCLES)+1); must never overflow.
- Reset mid-frame: scan restarts at row 0, BLANK, with a zero snapshot. Next frame_start is the first post-reset cycle.
- row_n and col are decoded from registered state only: no combinational path from `lines` to outputs.

Decomposition:
- Shared package: NUM_ROWS=7, NUM_COLS=5, LEVEL_WIDTH=2, column patterns COL_EMPTY/COL_LOW/COL_MID/COL_FULL, state encoding ST_BLANK/ST_SHOW.
- One sub-module: level_col_decoder (2-bit code → 5-bit column pattern, combinational).
- The scanner FSM, counters and snapshot register live in lines_matrix_scanner.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, row period 6, frame 42 unless noted):
1. Reset behaviour: assert init mid-SHOW → same-cycle row_n=7'h7F, col=0. Release init → frame_start=1 on the first cycle; row_idx=0, BLANK for 2 cycles.
2. Full scan: lines=14'b11_10_01_00_11_10_01 → rows 0..6 show col 00100, 01110, 11111, 00000, 00100, 01110, 11111.
   - Each row has row_n low for exactly 4 cycles, separated by 2 all-off cycles.
   - frame_start pulses every 42 cycles.
3. Tear-free update: change lines to 14'h3FFF while row 3 is lit → rows 3..6 keep the old patterns. The next frame shows 11111 on all rows.
4. Freeze: freeze=1 across a frame start with lines=14'h0000 and a prior snapshot of 14'h3FFF → the whole next frame still shows 11111. freeze=0 at the following frame start → all 00000.
5. Minimum timing: DWELL_CYCLES=1, BLANK_CYCLES=1 → rows alternate 1 off / 1 on. frame_start every 14 cycles; row_idx wraps 6→0.
6. Default timing: defaults (1000/8) → frame_start interval is exactly 7056 cycles. The first SHOW begins 8 cycles after reset release.
